// File: rtl/coin_acceptor.sv
// Coin sensor conditioner: synchronises and debounces two raw slot sensors and
// issues serialised one-cycle coin5/coin10 pulses. Optional feature: COIN_INHIBIT_EN.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic coin5_raw,
  input  logic coin10_raw,
  output logic coin5,
  output logic coin10
`ifdef COIN_INHIBIT_EN
  ,
  input  logic inhibit,
  output logic coin_return
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the 5-unit channel, bit 1 the 10-unit channel.
  logic [1:0] raw, s1, s2, deb, deb_q, rise;
  logic       pend5, pend10;
  logic       req5, req10, hold;

  assign raw = {coin10_raw, coin5_raw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb_q <= 2'b11;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             deb_r;

    // Debounced level starts high so a coin already sitting in the slot at
    // reset release is treated as present and never pulses.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        deb_r <= 1'b1;
      end else if (s2[ch] == deb_r) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb_r <= s2[ch];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[ch] = deb_r;
  end

  assign rise  = deb & ~deb_q;
  assign req5  = rise[0] | pend5;
  assign req10 = rise[1] | pend10;

`ifdef COIN_INHIBIT_EN
  assign hold = inhibit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) coin_return <= 1'b0;
    else       coin_return <= inhibit & (req5 | req10);
  end
`else
  assign hold = 1'b0;
`endif

  // coin5 wins a collision; a losing coin10 waits exactly one cycle in pend10.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin5  <= 1'b0;
      coin10 <= 1'b0;
      pend5  <= 1'b0;
      pend10 <= 1'b0;
    end else begin
      coin5  <= req5 & ~hold;
      coin10 <= req10 & ~req5 & ~hold;
      pend5  <= 1'b0;
      pend10 <= req10 & req5;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor (DEBOUNCE_CYCLES=4).
// Define COIN_INHIBIT_EN for both files to also exercise the inhibit path.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic reset;
  logic coin5_raw, coin10_raw;
  logic coin5, coin10;
`ifdef COIN_INHIBIT_EN
  logic inhibit, coin_return;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Pulse statistics gathered by run(): counts and 1-based tick of first pulse.
  int n5, n10, t5, t10, ovl;
`ifdef COIN_INHIBIT_EN
  int nret, tret;
`endif

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .coin5      (coin5),
    .coin10     (coin10)
`ifdef COIN_INHIBIT_EN
    ,
    .inhibit    (inhibit),
    .coin_return(coin_return)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n5 = 0; n10 = 0; t5 = -1; t10 = -1; ovl = 0;
`ifdef COIN_INHIBIT_EN
    nret = 0; tret = -1;
`endif
  endtask

  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (coin5 === 1'b1) begin
        n5++;
        if (t5 < 0) t5 = i;
      end
      if (coin10 === 1'b1) begin
        n10++;
        if (t10 < 0) t10 = i;
      end
      if (coin5 === 1'b1 && coin10 === 1'b1) ovl++;
`ifdef COIN_INHIBIT_EN
      if (coin_return === 1'b1) begin
        nret++;
        if (tret < 0) tret = i;
      end
`endif
    end
  endtask

  initial begin
    reset      = 1'b1;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
`ifdef COIN_INHIBIT_EN
    inhibit    = 1'b0;
`endif
    clear_stats();

    // Reset state
    tick();
    tick();
    check("reset_coin5", int'(coin5), 0);
    check("reset_coin10", int'(coin10), 0);
`ifdef COIN_INHIBIT_EN
    check("reset_coin_return", int'(coin_return), 0);
`endif
    reset = 1'b0;
    run(10);

    // Single coin5: pulse in the cycle after edge k+6 (7th tick)
    clear_stats();
    coin5_raw = 1'b1;
    run(12);
    check("c5_count", n5, 1);
    check("c5_latency", t5, 7);
    check("c5_no_coin10", n10, 0);
    coin5_raw = 1'b0;
    run(10);
    check("c5_fall_no_event", n5, 1);

    // Bounced coin10: 1,0,1,0 single-cycle glitches then steady high
    clear_stats();
    coin10_raw = 1'b1; tick();
    coin10_raw = 1'b0; tick();
    coin10_raw = 1'b1; tick();
    coin10_raw = 1'b0; tick();
    check("bounce_no_early", n10 + n5, 0);
    coin10_raw = 1'b1;
    run(12);
    check("bounce_count", n10, 1);
    check("bounce_latency", t10, 7);
    check("bounce_no_coin5", n5, 0);
    coin10_raw = 1'b0;
    run(10);

    // Simultaneous rises: coin5 first, coin10 one cycle later
    clear_stats();
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    run(12);
    check("sim_c5_count", n5, 1);
    check("sim_c10_count", n10, 1);
    check("sim_c5_tick", t5, 7);
    check("sim_c10_tick", t10, 8);
    check("sim_no_overlap", ovl, 0);
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    run(10);

    // coin5 held across reset release: no pulse until re-inserted
    coin5_raw = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_stats();
    run(15);
    check("held_reset_no_pulse", n5, 0);
    coin5_raw = 1'b0;
    run(10);
    check("held_drop_no_pulse", n5, 0);
    coin5_raw = 1'b1;
    run(12);
    check("reinsert_count", n5, 1);
    check("reinsert_latency", t5, 7);
    coin5_raw = 1'b0;
    run(10);

    // Reset while coin10 is deferred in pend10
    clear_stats();
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    run(7);
    check("pend_c5_issued", int'(coin5), 1);
    check("pend_c10_waiting", int'(coin10), 0);
    reset = 1'b1;
    #1;
    check("pend_reset_coin5", int'(coin5), 0);
    check("pend_reset_coin10", int'(coin10), 0);
    clear_stats();
    run(3);
    reset = 1'b0;
    run(15);
    check("pend_discarded_c10", n10, 0);
    check("pend_no_c5", n5, 0);
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    run(10);

`ifdef COIN_INHIBIT_EN
    // Inhibited issue returns the coin instead of forwarding it
    clear_stats();
    inhibit   = 1'b1;
    coin5_raw = 1'b1;
    run(12);
    check("inh_c5_suppressed", n5, 0);
    check("inh_return_count", nret, 1);
    check("inh_return_tick", tret, 7);
    coin5_raw = 1'b0;
    run(10);
    clear_stats();
    inhibit   = 1'b0;
    coin5_raw = 1'b1;
    run(12);
    check("uninh_c5_count", n5, 1);
    check("uninh_no_return", nret, 0);
    coin5_raw = 1'b0;
    run(10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
